// File: rtl/pulse_to_lvl.sv
// Turns single-cycle requests into acknowledged level pulses.
// Extra requests wait in a saturating queue, and a forced low gap separates each level.
module pulse_to_lvl #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned GAP_CYC  = 2,
  parameter int unsigned PEND_W   = 3
) (
  input  logic              UART_CLK,
  input  logic              i_rst,
  input  logic              PULSE_SIG,
  input  logic              ACK,
  output logic              LVL_SIG,
  output logic [PEND_W-1:0] PEND_CNT,
  output logic              OVERFLOW,
  output logic              TIMEOUT
);

  localparam int unsigned HOLD_W = $clog2(HOLD_MAX + 1);
  localparam int unsigned GAP_W  = $clog2(GAP_CYC + 1);
  localparam logic [PEND_W-1:0] PEND_FULL = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                lvl_q, lvl_d;
  logic                ovf_q, ovf_d;
  logic                to_q, to_d;
  logic                enq, deq;

  always_ff @(posedge UART_CLK or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      gap_q   <= '0;
      pend_q  <= '0;
      lvl_q   <= 1'b0;
      ovf_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      lvl_q   <= lvl_d;
      ovf_q   <= ovf_d;
      to_q    <= to_d;
    end
  end

  // Next state, counters and the queue enqueue/dequeue requests
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    to_d    = 1'b0;
    enq     = 1'b0;
    deq     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((pend_q != '0) || PULSE_SIG) begin
          state_d = HOLD;
          hold_d  = HOLD_W'(1);
          gap_d   = '0;
          // Queued requests start first; a live pulse then joins the queue
          deq     = (pend_q != '0);
          enq     = PULSE_SIG && (pend_q != '0);
        end
      end
      HOLD: begin
        enq = PULSE_SIG;
        if (ACK) begin
          state_d = GAP;
          gap_d   = GAP_W'(1);
          hold_d  = '0;
        end else if (hold_q == HOLD_W'(HOLD_MAX)) begin
          state_d = GAP;
          gap_d   = GAP_W'(1);
          hold_d  = '0;
          to_d    = 1'b1;
        end else begin
          hold_d  = hold_q + HOLD_W'(1);
        end
      end
      GAP: begin
        enq = PULSE_SIG;
        if (gap_q == GAP_W'(GAP_CYC)) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d   = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
        gap_d   = '0;
      end
    endcase
  end

  // Saturating pending counter; a dropped request raises the overflow flag
  always_comb begin
    pend_d = pend_q;
    ovf_d  = 1'b0;
    if (enq && !deq) begin
      if (pend_q == PEND_FULL) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (deq && !enq) begin
      pend_d = pend_q - PEND_W'(1);
    end
    lvl_d = (state_d == HOLD);
  end

  assign LVL_SIG  = lvl_q;
  assign PEND_CNT = pend_q;
  assign OVERFLOW = ovf_q;
  assign TIMEOUT  = to_q;

endmodule

// File: tb/tb_pulse_to_lvl.sv
// Directed bench for pulse_to_lvl at default parameters.
module tb_pulse_to_lvl;

  logic       clk;
  logic       rst;
  logic       pulse;
  logic       ack;
  logic       lvl;
  logic [2:0] pend;
  logic       ovf;
  logic       tmo;

  int tests = 0;
  int fails = 0;

  pulse_to_lvl #(.HOLD_MAX(16), .GAP_CYC(2), .PEND_W(3)) dut (
    .UART_CLK (clk),
    .i_rst    (rst),
    .PULSE_SIG(pulse),
    .ACK      (ack),
    .LVL_SIG  (lvl),
    .PEND_CNT (pend),
    .OVERFLOW (ovf),
    .TIMEOUT  (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Acknowledge the current level, then count low cycles until the next level (bounded)
  task automatic ack_and_wait(output int lows);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    lows = 0;
    while (!lvl && lows < 20) begin
      lows++;
      tick();
    end
  endtask

  int highs;
  int lows;
  int lv;
  int ovf_n;
  logic seen_to;
  logic seen_lvl;

  initial begin
    rst = 1'b1; pulse = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_lvl", 32'(lvl), 32'd0);
    check("rst_pend", 32'(pend), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_tmo", 32'(tmo), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Single request acknowledged in its fourth high cycle
    pulse = 1'b1; tick(); pulse = 1'b0;
    check("ack_lvl_first", 32'(lvl), 32'd1);
    check("ack_pend_zero", 32'(pend), 32'd0);
    repeat (3) tick();
    check("ack_lvl_fourth", 32'(lvl), 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("ack_lvl_drop", 32'(lvl), 32'd0);
    check("ack_no_tmo", 32'(tmo), 32'd0);
    repeat (2) tick();
    check("ack_gap_low", 32'(lvl), 32'd0);
    tick();
    check("ack_idle_low", 32'(lvl), 32'd0);
    check("ack_no_ovf", 32'(ovf), 32'd0);

    // Timeout with no acknowledge
    pulse = 1'b1; tick(); pulse = 1'b0;
    highs = 0;
    while (lvl && highs < 40) begin
      highs++;
      tick();
    end
    check("to_high_cycles", 32'(highs), 32'd16);
    check("to_flag", 32'(tmo), 32'd1);
    tick();
    check("to_flag_once", 32'(tmo), 32'd0);
    repeat (2) tick();

    // Acknowledge in the final hold cycle beats the timeout
    pulse = 1'b1; tick(); pulse = 1'b0;
    repeat (15) tick();
    check("race_lvl_last", 32'(lvl), 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("race_lvl_low", 32'(lvl), 32'd0);
    seen_to = tmo;
    repeat (5) begin tick(); seen_to |= tmo; end
    check("race_no_tmo", 32'(seen_to), 32'd0);

    // Acknowledge while idle has no effect
    ack = 1'b1; repeat (3) tick(); ack = 1'b0;
    check("idle_ack_lvl", 32'(lvl), 32'd0);
    check("idle_ack_pend", 32'(pend), 32'd0);
    check("idle_ack_tmo", 32'(tmo), 32'd0);

    // Three queued requests, each level preceded by three low cycles
    pulse = 1'b1; tick(); pulse = 1'b0;
    repeat (3) begin pulse = 1'b1; tick(); pulse = 1'b0; tick(); end
    check("q3_pend", 32'(pend), 32'd3);
    check("q3_lvl", 32'(lvl), 32'd1);
    for (int k = 0; k < 3; k++) begin
      ack_and_wait(lows);
      check("q3_low_gap", 32'(lows), 32'd3);
      check("q3_lvl_next", 32'(lvl), 32'd1);
      check("q3_pend_step", 32'(pend), 32'(2 - k));
    end
    ack_and_wait(lows);
    check("q3_no_extra", 32'(lvl), 32'd0);

    // Nine requests during a level saturate the queue at seven
    pulse = 1'b1; tick(); pulse = 1'b0; tick();
    ovf_n = 0;
    for (int i = 1; i <= 9; i++) begin
      pulse = 1'b1; tick();
      ovf_n += int'(ovf);
      check("sat_pend", 32'(pend), 32'((i < 7) ? i : 7));
    end
    pulse = 1'b0; tick();
    check("sat_ovf_count", 32'(ovf_n), 32'd2);
    check("sat_ovf_clear", 32'(ovf), 32'd0);
    lv = 0;
    repeat (9) begin
      ack_and_wait(lows);
      if (lvl) lv++;
    end
    check("sat_levels", 32'(lv), 32'd7);
    check("sat_pend_empty", 32'(pend), 32'd0);

    // Reset mid-hold discards the level and the queue immediately
    pulse = 1'b1; tick(); pulse = 1'b0;
    repeat (4) begin pulse = 1'b1; tick(); pulse = 1'b0; end
    check("rh_pend", 32'(pend), 32'd4);
    check("rh_lvl", 32'(lvl), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rh_lvl_async", 32'(lvl), 32'd0);
    check("rh_pend_async", 32'(pend), 32'd0);
    tick();
    rst = 1'b0;
    seen_to = 1'b0; seen_lvl = 1'b0;
    repeat (25) begin tick(); seen_to |= tmo; seen_lvl |= lvl; end
    check("rh_no_level", 32'(seen_lvl), 32'd0);
    check("rh_no_tmo", 32'(seen_to), 32'd0);

    // A request on the first edge after reset release is accepted
    rst = 1'b1; tick(); rst = 1'b0;
    pulse = 1'b1; tick(); pulse = 1'b0;
    check("post_rst_lvl", 32'(lvl), 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pulse_to_lvl.md
PULSE_TO_LVL -- requirements
Module: pulse_to_lvl

Interface
REQ-001 Parameter HOLD_MAX, default 16: maximum cycles LVL_SIG stays high without ACK; SHALL be >= 1.
REQ-002 Parameter GAP_CYC, default 2: forced low cycles after each level; SHALL be >= 1.
REQ-003 Parameter PEND_W, default 3: pending-request counter width; capacity is 2^PEND_W-1 (7 by default).
REQ-004 UART_CLK  input  1  single block clock; all logic on its rising edge.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 PULSE_SIG  input  1  request; each cycle sampled high is one request.
REQ-007 ACK  input  1  consumer acknowledge; meaningful only while LVL_SIG is high.
REQ-008 LVL_SIG  output  1  registered level output.
REQ-009 PEND_CNT  output  PEND_W  registered count of queued requests.
REQ-010 OVERFLOW  output  1  registered one-cycle flag: a request was dropped.
REQ-011 TIMEOUT  output  1  registered one-cycle flag: a level ended without ACK.

Function
REQ-012 FSM states IDLE, HOLD, GAP; LVL_SIG SHALL be 1 only in HOLD.
REQ-013 IDLE -> HOLD when PEND_CNT > 0 or PULSE_SIG = 1; otherwise stay in IDLE.
REQ-014 Start source: pending queue first if PEND_CNT > 0, else the live pulse; a start consumes exactly one request.
REQ-015 Latency: PULSE_SIG high in cycle n while in IDLE with PEND_CNT = 0 -> LVL_SIG high from cycle n+1.
REQ-016 Hold counter resets to 1 on HOLD entry and increments each HOLD cycle.
REQ-017 HOLD -> GAP when ACK is sampled high; LVL_SIG SHALL be low the next cycle, so the minimum level is 1 cycle.
REQ-018 HOLD -> GAP when the hold counter = HOLD_MAX and ACK is low; TIMEOUT SHALL be high for exactly the first GAP cycle.
REQ-019 ACK and timeout in the same cycle: ACK wins and TIMEOUT SHALL stay 0.
REQ-020 GAP SHALL last exactly GAP_CYC cycles, then go to IDLE; total low time between queued levels is GAP_CYC+1 cycles.
REQ-021 ACK in IDLE or GAP SHALL be ignored, with no state or flag effect.
REQ-022 PULSE_SIG high in HOLD or GAP, or in IDLE while a pending request is being consumed, SHALL enqueue the request (PEND_CNT +1).
REQ-023 Same-cycle enqueue and dequeue SHALL leave PEND_CNT unchanged.
REQ-024 Enqueue at PEND_CNT = 2^PEND_W-1 (with no same-cycle dequeue): the request is dropped, PEND_CNT stays saturated (no wrap), and OVERFLOW is high the next cycle for 1 cycle.
REQ-025 OVERFLOW and TIMEOUT SHALL be independent and may assert in the same cycle.

Reset
REQ-026 While i_rst = 1, asynchronously: state = IDLE, LVL_SIG = 0, PEND_CNT = 0, OVERFLOW = 0, TIMEOUT = 0, hold and gap counters = 0.
REQ-027 Reset mid-HOLD or mid-GAP SHALL discard the active level and all pending requests, and SHALL generate no TIMEOUT.
REQ-028 First request accepted on the first rising edge after i_rst deasserts.

Verification (defaults HOLD_MAX=16, GAP_CYC=2, PEND_W=3)
REQ-029 PULSE_SIG high cycle 10, ACK high cycle 14 -> LVL_SIG high cycles 11-14, low 15-17; IDLE in cycle 17; no flags.
REQ-030 PULSE_SIG high cycle 10, no ACK -> LVL_SIG high cycles 11-26 (16 cycles); TIMEOUT high in cycle 27 only.
REQ-031 ACK high exactly in cycle 26 of the REQ-030 scenario -> LVL_SIG low from 27; TIMEOUT never asserts.
REQ-032 Three 1-cycle pulses during HOLD -> PEND_CNT reaches 3; then three further levels, each preceded by 3 low cycles; PEND_CNT steps 3->2->1->0 on each HOLD entry.
REQ-033 Nine 1-cycle pulses during HOLD -> PEND_CNT saturates at 7; OVERFLOW pulses once each for the 8th and 9th pulse; exactly 7 queued levels follow.
REQ-034 i_rst pulsed mid-HOLD with PEND_CNT = 4 -> LVL_SIG = 0 and PEND_CNT = 0 immediately (before the next edge); no further levels without new pulses.
